// File: rtl/ymem_capture_if.sv
// Bundle between the accelerator result stream, the CPU read port and the capture buffer.
// The slave side is the capture block; the master side drives start, stream words and reads.
interface ymem_capture_if #(
    parameter int AW = 10,
    parameter int IW = 4
);
    logic          start;
    logic          acc_valid;
    logic [31:0]   acc_data;
    logic          acc_ready;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          done;
    logic [AW:0]   count;
    logic [IW-1:0] pred_idx;
    logic [31:0]   pred_val;

    modport master (
        output start, acc_valid, acc_data, mem_valid, mem_addr,
        input  acc_ready, mem_ready, mem_rdata, done, count,
        input  pred_idx, pred_val
    );

    modport slave (
        input  start, acc_valid, acc_data, mem_valid, mem_addr,
        output acc_ready, mem_ready, mem_rdata, done, count,
        output pred_idx, pred_val
    );
endinterface

// File: rtl/ymem_capture.sv
// Result capture buffer: stores accelerator output words per image and tracks
// a running signed argmax so the CPU can read back scores and the predicted class.
module ymem_capture #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int NRES  = 10,
    parameter int IW    = 4
) (
    input logic          clk,
    input logic          resetn,
    ymem_capture_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [AW:0] LAST     = (AW+1)'(NRES - 1);
    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

    state_t      state;
    logic [31:0] mem [DEPTH];
    logic        xfer;
    logic        rd_go;

    // start wins over a coincident transfer: the word is dropped
    assign xfer  = bus.acc_valid & bus.acc_ready & ~bus.start;
    assign rd_go = bus.mem_valid & ~bus.mem_ready;

    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[bus.count[AW-1:0]] <= bus.acc_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            bus.acc_ready <= 1'b0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            bus.done      <= 1'b0;
            bus.count     <= '0;
            bus.pred_idx  <= '0;
            bus.pred_val  <= '0;
        end else begin
            bus.mem_ready <= rd_go;
            if (rd_go) begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end

            if (bus.start) begin
                state         <= CAPTURE;
                bus.acc_ready <= 1'b1;
                bus.done      <= 1'b0;
                bus.count     <= '0;
                bus.pred_idx  <= '0;
                bus.pred_val  <= MOST_NEG;
            end else begin
                unique case (state)
                    IDLE: begin
                        bus.acc_ready <= 1'b0;
                    end
                    CAPTURE: begin
                        if (xfer) begin
                            bus.count <= bus.count + 1'b1;
                            if ($signed(bus.acc_data) > $signed(bus.pred_val)) begin
                                bus.pred_val <= bus.acc_data;
                                bus.pred_idx <= IW'(bus.count);
                            end
                            if (bus.count == LAST) begin
                                state         <= DONE;
                                bus.acc_ready <= 1'b0;
                                bus.done      <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        bus.acc_ready <= 1'b0;
                    end
                    default: begin
                        state         <= IDLE;
                        bus.acc_ready <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ymem_capture.sv
// Bench for ymem_capture: table of images with expected argmax, readback
// through a queue of expected words, plus restart/ignore/reset sequences.
module tb_ymem_capture;
    logic clk;
    logic resetn;
    int   nvec;
    int   nerr;

    ymem_capture_if #(.AW(10), .IW(4)) bus ();

    ymem_capture #(
        .DEPTH(1024),
        .AW(10),
        .NRES(10),
        .IW(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    typedef struct {
        logic [0:9][31:0] w;
        int               gap;
        logic [3:0]       idx;
        logic [31:0]      val;
    } vec_t;

    vec_t        tbl[5];
    logic [31:0] ref_mem[1024];
    logic [31:0] rq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s act=%0h req=%0h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [9:0] a);
        int t;
        rq.push_back(ref_mem[a]);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        step();
        t = 1;
        while (bus.mem_ready !== 1'b1 && t < 5) begin
            step();
            t++;
        end
        chk("rd_lat", 64'(t), 64'd1);
        if (bus.mem_ready === 1'b1) begin
            chk("rd_data", 64'(bus.mem_rdata), 64'(rq.pop_front()));
        end else begin
            void'(rq.pop_front());
        end
        bus.mem_valid = 1'b0;
        step();
        chk("rd_pulse", 64'(bus.mem_ready), 64'd0);
        chk("rd_hold", 64'(bus.mem_rdata), 64'(ref_mem[a]));
    endtask

    task automatic feed(input logic [0:9][31:0] w, input int n, input int gap,
                        input bit do_start, output int hi);
        hi = 0;
        if (do_start) begin
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            chk("start_cnt", 64'(bus.count), 64'd0);
            chk("start_pv", 64'(bus.pred_val), 64'h8000_0000);
            chk("start_rdy", 64'(bus.acc_ready), 64'd1);
        end
        for (int i = 0; i < n; i++) begin
            if (i == 9) chk("pre_done", 64'(bus.done), 64'd0);
            bus.acc_valid = 1'b1;
            bus.acc_data  = w[i];
            hi += int'(bus.acc_ready);
            step();
            ref_mem[i] = w[i];
            if (gap > 0) begin
                bus.acc_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    hi += int'(bus.acc_ready);
                    step();
                end
            end
        end
        bus.acc_valid = 1'b0;
    endtask

    task automatic chk_done(input logic [3:0] idx, input logic [31:0] val);
        chk("done", 64'(bus.done), 64'd1);
        chk("count", 64'(bus.count), 64'd10);
        chk("rdy_off", 64'(bus.acc_ready), 64'd0);
        chk("pred_idx", 64'(bus.pred_idx), 64'(idx));
        chk("pred_val", 64'(bus.pred_val), 64'(val));
    endtask

    initial begin
        int hi;
        logic [0:9][31:0] part;
        nvec = 0;
        nerr = 0;

        tbl[0].w = '{32'd3, 32'(-5), 32'd7, 32'd2, 32'd7, 32'd0, 32'(-1), 32'd6, 32'd1, 32'd4};
        tbl[0].gap = 0; tbl[0].idx = 4'd2; tbl[0].val = 32'd7;
        tbl[1].w = '{32'(-8), 32'(-9), 32'(-10), 32'(-11), 32'(-12),
                     32'(-13), 32'(-14), 32'(-15), 32'(-16), 32'(-17)};
        tbl[1].gap = 0; tbl[1].idx = 4'd0; tbl[1].val = 32'hFFFF_FFF8;
        tbl[2].w = '{32'd10, 32'd20, 32'(-30), 32'd40, 32'd50, 32'd45, 32'(-1), 32'd0, 32'd50, 32'd12};
        tbl[2].gap = 2; tbl[2].idx = 4'd4; tbl[2].val = 32'd50;
        tbl[3].w = '{10{32'h8000_0000}};
        tbl[3].gap = 1; tbl[3].idx = 4'd0; tbl[3].val = 32'h8000_0000;
        tbl[4].w = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'h7FFF_FFFF};
        tbl[4].gap = 0; tbl[4].idx = 4'd9; tbl[4].val = 32'h7FFF_FFFF;

        resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.acc_valid = 1'b0;
        bus.acc_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        step();
        step();
        chk("rst_rdy", 64'(bus.acc_ready), 64'd0);
        chk("rst_cnt", 64'(bus.count), 64'd0);
        chk("rst_pv", 64'(bus.pred_val), 64'd0);
        chk("rst_rdata", 64'(bus.mem_rdata), 64'd0);
        resetn = 1'b1;
        step();

        // stream words while idle
        bus.acc_valid = 1'b1;
        bus.acc_data  = 32'd77;
        step();
        step();
        bus.acc_valid = 1'b0;
        chk("idle_rdy", 64'(bus.acc_ready), 64'd0);
        chk("idle_cnt", 64'(bus.count), 64'd0);
        chk("idle_done", 64'(bus.done), 64'd0);

        for (int v = 0; v < 5; v++) begin
            feed(tbl[v].w, 10, tbl[v].gap, 1'b1, hi);
            chk_done(tbl[v].idx, tbl[v].val);
            if (tbl[v].gap == 0) chk("rdy_cycles", 64'(hi), 64'd10);
            for (int a = 0; a < 10; a++) rd(10'(a));
        end

        // restart after 4 words
        part = '{10{32'd100}};
        feed(part, 4, 0, 1'b1, hi);
        chk("part_cnt", 64'(bus.count), 64'd4);
        chk("part_pv", 64'(bus.pred_val), 64'd100);
        feed(tbl[0].w, 10, 0, 1'b1, hi);
        chk_done(4'd2, 32'd7);
        for (int a = 0; a < 10; a++) rd(10'(a));

        // start coincident with a transfer
        feed(tbl[1].w, 2, 0, 1'b1, hi);
        chk("co_pre_cnt", 64'(bus.count), 64'd2);
        bus.start     = 1'b1;
        bus.acc_valid = 1'b1;
        bus.acc_data  = 32'd555;
        step();
        bus.start     = 1'b0;
        bus.acc_valid = 1'b0;
        chk("co_cnt", 64'(bus.count), 64'd0);
        chk("co_pv", 64'(bus.pred_val), 64'h8000_0000);
        chk("co_rdy", 64'(bus.acc_ready), 64'd1);
        rd(10'd2);
        feed(tbl[2].w, 10, 0, 1'b0, hi);
        chk_done(4'd4, 32'd50);

        // stream words while done
        bus.acc_valid = 1'b1;
        bus.acc_data  = 32'd999;
        step();
        step();
        step();
        bus.acc_valid = 1'b0;
        chk_done(4'd4, 32'd50);
        for (int a = 0; a < 10; a++) rd(10'(a));

        // asynchronous reset mid-capture
        rd(10'd4);
        feed(tbl[4].w, 5, 0, 1'b1, hi);
        chk("mid_cnt", 64'(bus.count), 64'd5);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_rdy", 64'(bus.acc_ready), 64'd0);
        chk("arst_cnt", 64'(bus.count), 64'd0);
        chk("arst_idx", 64'(bus.pred_idx), 64'd0);
        chk("arst_pv", 64'(bus.pred_val), 64'd0);
        chk("arst_rdata", 64'(bus.mem_rdata), 64'd0);
        step();
        resetn = 1'b1;
        step();
        feed(tbl[0].w, 10, 0, 1'b1, hi);
        chk_done(4'd2, 32'd7);
        for (int a = 0; a < 10; a++) rd(10'(a));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
